// File: rtl/card_blit_reader.sv
// Copies one 16x32 card sprite from its memory into the 256x240 framebuffer at a latched origin.
// Optional TRANSPARENT_KEY_EN: colour-0 pixels are skipped (fbWE low, timing unchanged).
module card_blit_reader #(
  parameter int unsigned CARD_W  = 16,
  parameter int unsigned CARD_H  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned FB_W    = 256,
  parameter int unsigned FB_H    = 240
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         cardX,
  input  logic [7:0]         cardY,
  output logic               cardRE,
  output logic [ADDR_W-1:0]  cardAddr,
  input  logic [COLOR_W-1:0] cardData,
  output logic               fbWE,
  output logic [15:0]        fbAddr,
  output logic [COLOR_W-1:0] fbData,
  output logic               busy,
  output logic               done
);

  localparam int unsigned COL_W = $clog2(CARD_W);
  localparam int unsigned ROW_W = $clog2(CARD_H);
  localparam int unsigned CRD_W = 9;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [7:0]           x0_q, x0_d, y0_q, y0_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COL_W-1:0]     col_q, col_d, col1_q;
  logic [ROW_W-1:0]     row_q, row_d, row1_q;
  logic                 drain_q, drain_d;
  logic                 re_q, re_d, busy_q, busy_d, done_q, done_d;
  logic                 v1_q;
  logic                 we_q, we_d;
  logic [15:0]          fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0]   fb_data_q, fb_data_d;
  logic [CRD_W-1:0]     x_c, y_c;
  logic                 keep_c;

  // Next state, read counters and registered status outputs
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          x0_d    = cardX;
          y0_d    = cardY;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FETCH: begin
        if (addr_q == ADDR_W'(CARD_W * CARD_H - 1)) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == COL_W'(CARD_W - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    re_d   = (state_d == S_FETCH);
    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Write stage: 9-bit coordinates so off-screen pixels clip instead of wrapping
  always_comb begin
    x_c = {1'b0, x0_q} + CRD_W'(col1_q);
    y_c = {1'b0, y0_q} + CRD_W'(row1_q);
`ifdef TRANSPARENT_KEY_EN
    keep_c = (cardData != '0);
`else
    keep_c = 1'b1;
`endif
    we_d      = v1_q && (x_c < CRD_W'(FB_W)) && (y_c < CRD_W'(FB_H)) && keep_c;
    fb_addr_d = we_d ? {y_c[7:0], x_c[7:0]} : fb_addr_q;
    fb_data_d = we_d ? cardData : fb_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      addr_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      drain_q   <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      col1_q    <= '0;
      row1_q    <= '0;
      we_q      <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      drain_q   <= drain_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      v1_q      <= re_q;
      col1_q    <= col_q;
      row1_q    <= row_q;
      we_q      <= we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign cardRE   = re_q;
  assign cardAddr = addr_q;
  assign fbWE     = we_q;
  assign fbAddr   = fb_addr_q;
  assign fbData   = fb_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
